// File: rtl/user_apb_master_if.sv
// apb4_if: APB4 bus bundle shared by one requester and one completer.
//
// Parameters:
//   ADDR_WIDTH - width of paddr
//   DATA_WIDTH - width of pwdata/prdata; pstrb is DATA_WIDTH/8 bits wide
//
// Signals:
//   paddr, pprot, psel, penable, pwrite, pwdata, pstrb - requester to completer
//   pready, prdata, pslverr                            - completer to requester
//
// Modports:
//   master - the requester side (drives the request signals)
//   slave  - the completer side (drives pready/prdata/pslverr)
interface apb4_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
);
   logic [ADDR_WIDTH-1:0]   paddr;
   logic [2:0]              pprot;
   logic                    psel;
   logic                    penable;
   logic                    pwrite;
   logic [DATA_WIDTH-1:0]   pwdata;
   logic [DATA_WIDTH/8-1:0] pstrb;
   logic                    pready;
   logic [DATA_WIDTH-1:0]   prdata;
   logic                    pslverr;

   modport master (
      output paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      input  pready, prdata, pslverr
   );

   modport slave (
      input  paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
      output pready, prdata, pslverr
   );
endinterface

// File: rtl/user_apb_master.sv
// user_apb_master: APB4 requester. Turns one command from a valid/ready
// command channel into exactly one APB4 transfer and returns read data and
// error status on a valid/ready response channel. One transfer in flight.
//
// Optional feature macro: USER_APB_MST_TIMEOUT_EN
//   Defined   - ACCESS phase is aborted after TIMEOUT_CYCLES wait cycles with
//               an error response and a one-cycle timeout_o pulse.
//   Undefined - ACCESS waits for pready indefinitely; timeout_o is tied to 0.
//
// Parameters:
//   ADDR_WIDTH     - address width (cmd_addr_i, paddr)
//   DATA_WIDTH     - data width; strobe width is DATA_WIDTH/8
//   TIMEOUT_CYCLES - ACCESS wait limit, 1..65535 (timeout build only)
//
// Ports:
//   clk_i, rst_n_i                  - clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o       - command handshake
//   cmd_write_i, cmd_addr_i, cmd_wdata_i, cmd_wstrb_i, cmd_prot_i - command
//   rsp_valid_o / rsp_ready_i       - response handshake
//   rsp_rdata_o, rsp_err_o          - response payload
//   busy_o                          - high whenever the FSM is not IDLE
//   timeout_o                       - one-cycle pulse on timeout abort
//   apb                             - APB4 requester port
//
// Handshake rule for both channels: a transfer happens on a rising clk_i edge
// where valid and ready are both high. Valid, once raised, is held with its
// payload stable until that edge; ready never depends on valid.
module user_apb_master #(
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                    clk_i,
   input  logic                    rst_n_i,
   input  logic                    cmd_valid_i,
   output logic                    cmd_ready_o,
   input  logic                    cmd_write_i,
   input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
   input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
   input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
   input  logic [2:0]              cmd_prot_i,
   output logic                    rsp_valid_o,
   input  logic                    rsp_ready_i,
   output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
   output logic                    rsp_err_o,
   output logic                    busy_o,
   output logic                    timeout_o,
   apb4_if.master                  apb
);

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_SETUP  = 2'd1;
   localparam logic [1:0] ST_ACCESS = 2'd2;
   localparam logic [1:0] ST_RESP   = 2'd3;

   // Elaboration-time guard on the wait limit.
   if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_timeout_range
      $error("user_apb_master: TIMEOUT_CYCLES must be in 1..65535");
   end

   logic [1:0] state;

`ifdef USER_APB_MST_TIMEOUT_EN
   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);
   logic [15:0] wait_cnt;
`else
   assign timeout_o = 1'b0;
`endif

   // Only IDLE can take a command, so ready is a pure state decode.
   assign cmd_ready_o = (state == ST_IDLE);
   assign busy_o      = (state != ST_IDLE);

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state       <= ST_IDLE;
         apb.paddr   <= '0;
         apb.pprot   <= '0;
         apb.psel    <= 1'b0;
         apb.penable <= 1'b0;
         apb.pwrite  <= 1'b0;
         apb.pwdata  <= '0;
         apb.pstrb   <= '0;
         rsp_valid_o <= 1'b0;
         rsp_rdata_o <= '0;
         rsp_err_o   <= 1'b0;
`ifdef USER_APB_MST_TIMEOUT_EN
         wait_cnt    <= '0;
         timeout_o   <= 1'b0;
`endif
      end else begin
`ifdef USER_APB_MST_TIMEOUT_EN
         timeout_o <= 1'b0;
`endif
         case (state)
            ST_IDLE: begin
               if (cmd_valid_i) begin
                  // Reads must present zero strobes; zero data as well so a
                  // read never leaks stale write data onto the bus.
                  apb.paddr  <= cmd_addr_i;
                  apb.pprot  <= cmd_prot_i;
                  apb.pwrite <= cmd_write_i;
                  apb.pwdata <= cmd_write_i ? cmd_wdata_i : '0;
                  apb.pstrb  <= cmd_write_i ? cmd_wstrb_i : '0;
                  apb.psel   <= 1'b1;
                  state      <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               apb.penable <= 1'b1;
`ifdef USER_APB_MST_TIMEOUT_EN
               wait_cnt    <= '0;
`endif
               state       <= ST_ACCESS;
            end
            ST_ACCESS: begin
               if (apb.pready) begin
                  // Completion beats a timeout that would fire in this cycle.
                  rsp_rdata_o <= apb.pwrite ? '0 : apb.prdata;
                  rsp_err_o   <= apb.pslverr;
                  rsp_valid_o <= 1'b1;
                  apb.psel    <= 1'b0;
                  apb.penable <= 1'b0;
                  state       <= ST_RESP;
               end
`ifdef USER_APB_MST_TIMEOUT_EN
               else if (wait_cnt == TIMEOUT_LIMIT) begin
                  rsp_rdata_o <= '0;
                  rsp_err_o   <= 1'b1;
                  rsp_valid_o <= 1'b1;
                  apb.psel    <= 1'b0;
                  apb.penable <= 1'b0;
                  timeout_o   <= 1'b1;
                  state       <= ST_RESP;
               end else begin
                  wait_cnt <= wait_cnt + 16'd1;
               end
`endif
            end
            ST_RESP: begin
               // Payload registers are left alone so they hold after handshake.
               if (rsp_ready_i) begin
                  rsp_valid_o <= 1'b0;
                  state       <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_user_apb_master.sv
// tb_user_apb_master: directed, table-driven bench for user_apb_master.
// Single transfers come from a vector table; backpressure, timeout/endless
// wait and asynchronous reset during ACCESS are hand-written sequences.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_user_apb_master;

   logic        clk;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic        cmd_write;
   logic [31:0] cmd_addr;
   logic [31:0] cmd_wdata;
   logic [3:0]  cmd_wstrb;
   logic [2:0]  cmd_prot;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic        busy;
   logic        timeout;

   apb4_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) apb_bus ();

   user_apb_master #(
      .ADDR_WIDTH(32),
      .DATA_WIDTH(32),
      .TIMEOUT_CYCLES(4)
   ) dut (
      .clk_i      (clk),
      .rst_n_i    (rst_n),
      .cmd_valid_i(cmd_valid),
      .cmd_ready_o(cmd_ready),
      .cmd_write_i(cmd_write),
      .cmd_addr_i (cmd_addr),
      .cmd_wdata_i(cmd_wdata),
      .cmd_wstrb_i(cmd_wstrb),
      .cmd_prot_i (cmd_prot),
      .rsp_valid_o(rsp_valid),
      .rsp_ready_i(rsp_ready),
      .rsp_rdata_o(rsp_rdata),
      .rsp_err_o  (rsp_err),
      .busy_o     (busy),
      .timeout_o  (timeout),
      .apb        (apb_bus)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic chk(input string tag, input string what,
                      input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s.%s: got %0h expected %0h", tag, what, act, exp);
      end
   endtask

   // ---------------- vector table ----------------
   typedef struct {
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [2:0]  prot;
      int          waits;
      logic [31:0] prdata;
      logic        pslverr;
      logic [31:0] exp_rdata;
      logic        exp_err;
      logic [3:0]  exp_pstrb;
      logic [31:0] exp_pwdata;
   } vec_t;

   localparam int NVEC = 6;
   vec_t vecs[NVEC];

   task automatic drive_cmd(input vec_t v);
      cmd_valid = 1'b1;
      cmd_write = v.write;
      cmd_addr  = v.addr;
      cmd_wdata = v.wdata;
      cmd_wstrb = v.wstrb;
      cmd_prot  = v.prot;
   endtask

   // Runs one transfer starting at a falling edge in IDLE. Cycle 0 = accept.
   task automatic run_vec(input vec_t v, input string tag);
      @(negedge clk);
      drive_cmd(v);
      rsp_ready      = 1'b0;
      apb_bus.pready = 1'b0;
      chk(tag, "cmd_ready_idle", cmd_ready, 1);
      @(negedge clk);                       // cycle 1: SETUP
      cmd_valid = 1'b0;
      chk(tag, "setup_psel", apb_bus.psel, 1);
      chk(tag, "setup_penable", apb_bus.penable, 0);
      chk(tag, "paddr", apb_bus.paddr, v.addr);
      chk(tag, "pwrite", apb_bus.pwrite, v.write);
      chk(tag, "pwdata", apb_bus.pwdata, v.exp_pwdata);
      chk(tag, "pstrb", apb_bus.pstrb, v.exp_pstrb);
      chk(tag, "pprot", apb_bus.pprot, v.prot);
      chk(tag, "busy_setup", busy, 1);
      chk(tag, "cmd_ready_busy", cmd_ready, 0);
      @(negedge clk);                       // cycle 2: ACCESS
      chk(tag, "access_psel", apb_bus.psel, 1);
      chk(tag, "access_penable", apb_bus.penable, 1);
      for (int i = 0; i < v.waits; i++) begin
         apb_bus.pready = 1'b0;
         apb_bus.prdata = 32'h0BAD_F00D;
         @(negedge clk);
         chk(tag, "wait_penable", apb_bus.penable, 1);
         chk(tag, "wait_paddr", apb_bus.paddr, v.addr);
         chk(tag, "wait_pstrb", apb_bus.pstrb, v.exp_pstrb);
         chk(tag, "wait_rsp_valid", rsp_valid, 0);
      end
      apb_bus.pready  = 1'b1;
      apb_bus.prdata  = v.prdata;
      apb_bus.pslverr = v.pslverr;
      @(negedge clk);                       // cycle 3 + waits: RESP
      apb_bus.pready  = 1'b0;
      apb_bus.prdata  = 32'hBAD0_BAD0;
      apb_bus.pslverr = 1'b0;
      chk(tag, "rsp_valid", rsp_valid, 1);
      chk(tag, "rsp_rdata", rsp_rdata, v.exp_rdata);
      chk(tag, "rsp_err", rsp_err, v.exp_err);
      chk(tag, "resp_psel", apb_bus.psel, 0);
      chk(tag, "resp_penable", apb_bus.penable, 0);
      chk(tag, "timeout_idle", timeout, 0);
      chk(tag, "cmd_ready_resp", cmd_ready, 0);
      rsp_ready = 1'b1;
      @(negedge clk);                       // back in IDLE
      rsp_ready = 1'b0;
      chk(tag, "rsp_valid_clr", rsp_valid, 0);
      chk(tag, "cmd_ready_after", cmd_ready, 1);
      chk(tag, "busy_after", busy, 0);
      chk(tag, "rdata_hold", rsp_rdata, v.exp_rdata);
      chk(tag, "err_hold", rsp_err, v.exp_err);
   endtask

   // ---------------- main sequence ----------------
   vec_t bp;
   vec_t nxt;

   initial begin
      //            wr    addr          wdata         wstrb  prot   wt prdata        err   exp_rdata     exp_err pstrb  pwdata
      vecs[0] = '{1'b1, 32'h0000_0004, 32'hDEAD_BEEF, 4'hF, 3'b000, 0, 32'h1111_2222, 1'b0, 32'h0,         1'b0, 4'hF, 32'hDEAD_BEEF};
      vecs[1] = '{1'b0, 32'h0000_0000, 32'h7777_7777, 4'hF, 3'b000, 3, 32'h0000_00FF, 1'b0, 32'h0000_00FF, 1'b0, 4'h0, 32'h0};
      vecs[2] = '{1'b0, 32'h0000_0020, 32'h0,         4'h0, 3'b010, 0, 32'h1234_5678, 1'b1, 32'h1234_5678, 1'b1, 4'h0, 32'h0};
      vecs[3] = '{1'b1, 32'h0000_0100, 32'hA5A5_0F0F, 4'h5, 3'b001, 1, 32'hAAAA_5555, 1'b1, 32'h0,         1'b1, 4'h5, 32'hA5A5_0F0F};
      vecs[4] = '{1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFF, 4'hA, 3'b101, 2, 32'h8000_0001, 1'b0, 32'h8000_0001, 1'b0, 4'h0, 32'h0};
      vecs[5] = '{1'b1, 32'h0000_0008, 32'h0000_0001, 4'h1, 3'b111, 0, 32'h0,         1'b0, 32'h0,         1'b0, 4'h1, 32'h0000_0001};

      rst_n           = 1'b0;
      cmd_valid       = 1'b0;
      cmd_write       = 1'b0;
      cmd_addr        = '0;
      cmd_wdata       = '0;
      cmd_wstrb       = '0;
      cmd_prot        = '0;
      rsp_ready       = 1'b0;
      apb_bus.pready  = 1'b0;
      apb_bus.prdata  = '0;
      apb_bus.pslverr = 1'b0;

      // ---- reset values ----
      #22;
      chk("reset", "psel", apb_bus.psel, 0);
      chk("reset", "penable", apb_bus.penable, 0);
      chk("reset", "pwrite", apb_bus.pwrite, 0);
      chk("reset", "paddr", apb_bus.paddr, 0);
      chk("reset", "pwdata", apb_bus.pwdata, 0);
      chk("reset", "pstrb", apb_bus.pstrb, 0);
      chk("reset", "pprot", apb_bus.pprot, 0);
      chk("reset", "rsp_valid", rsp_valid, 0);
      chk("reset", "rsp_rdata", rsp_rdata, 0);
      chk("reset", "rsp_err", rsp_err, 0);
      chk("reset", "timeout", timeout, 0);
      chk("reset", "busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("reset", "cmd_ready", cmd_ready, 1);

      // ---- table-driven single transfers ----
      for (int i = 0; i < NVEC; i++) begin
         run_vec(vecs[i], $sformatf("vec%0d", i));
      end

      // ---- response backpressure with the next command already waiting ----
      bp  = '{1'b0, 32'h0000_0010, 32'h0, 4'h0, 3'b000, 0, 32'h5A5A_0001, 1'b0,
              32'h5A5A_0001, 1'b0, 4'h0, 32'h0};
      nxt = '{1'b1, 32'h0000_0014, 32'hCAFE_F00D, 4'h3, 3'b000, 0, 32'h0, 1'b0,
              32'h0, 1'b0, 4'h3, 32'hCAFE_F00D};
      @(negedge clk);
      drive_cmd(bp);
      @(negedge clk);                       // SETUP
      drive_cmd(nxt);                       // next command held from here on
      @(negedge clk);                       // ACCESS
      apb_bus.pready = 1'b1;
      apb_bus.prdata = bp.prdata;
      @(negedge clk);                       // RESP
      apb_bus.pready = 1'b0;
      apb_bus.prdata = 32'h0;
      for (int i = 0; i < 5; i++) begin
         chk("bp", "rsp_valid", rsp_valid, 1);
         chk("bp", "rsp_rdata", rsp_rdata, 32'h5A5A_0001);
         chk("bp", "rsp_err", rsp_err, 0);
         chk("bp", "cmd_ready", cmd_ready, 0);
         chk("bp", "psel", apb_bus.psel, 0);
         @(negedge clk);
      end
      chk("bp", "rsp_valid_end", rsp_valid, 1);
      rsp_ready = 1'b1;
      @(negedge clk);                       // IDLE: next command accepted here
      rsp_ready = 1'b0;
      chk("bp", "rsp_valid_clr", rsp_valid, 0);
      chk("bp", "cmd_ready_idle", cmd_ready, 1);
      @(negedge clk);                       // SETUP of the held command
      cmd_valid = 1'b0;
      chk("bp", "next_psel", apb_bus.psel, 1);
      chk("bp", "next_paddr", apb_bus.paddr, 32'h0000_0014);
      chk("bp", "next_pstrb", apb_bus.pstrb, 4'h3);
      @(negedge clk);                       // ACCESS
      apb_bus.pready = 1'b1;
      @(negedge clk);                       // RESP
      apb_bus.pready = 1'b0;
      chk("bp", "next_rsp_valid", rsp_valid, 1);
      chk("bp", "next_rdata", rsp_rdata, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;

      // ---- stuck slave: a read that never gets pready ----
      // Leave a non-zero rdata behind so a zeroed timeout rdata is observable.
      run_vec(vecs[1], "pre_to");
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_addr  = 32'h0000_0030;
      cmd_prot  = 3'b000;
      apb_bus.pready = 1'b0;
      apb_bus.prdata = 32'hCAFE_0000;
      @(negedge clk);                       // cycle 1 SETUP
      cmd_valid = 1'b0;
      @(negedge clk);                       // cycle 2 ACCESS, wait count 0
`ifdef USER_APB_MST_TIMEOUT_EN
      repeat (4) @(negedge clk);            // cycle 6, wait count 4
      chk("to", "psel_before", apb_bus.psel, 1);
      chk("to", "pulse_before", timeout, 0);
      chk("to", "rsp_valid_before", rsp_valid, 0);
      @(negedge clk);                       // cycle 7: aborted
      chk("to", "pulse", timeout, 1);
      chk("to", "rsp_valid", rsp_valid, 1);
      chk("to", "rsp_err", rsp_err, 1);
      chk("to", "rsp_rdata", rsp_rdata, 0);
      chk("to", "psel", apb_bus.psel, 0);
      chk("to", "penable", apb_bus.penable, 0);
      @(negedge clk);
      chk("to", "pulse_end", timeout, 0);
      chk("to", "psel_after", apb_bus.psel, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("to", "idle", cmd_ready, 1);
`else
      repeat (1000) @(negedge clk);
      chk("nto", "psel", apb_bus.psel, 1);
      chk("nto", "penable", apb_bus.penable, 1);
      chk("nto", "rsp_valid", rsp_valid, 0);
      chk("nto", "timeout", timeout, 0);
      chk("nto", "busy", busy, 1);
      apb_bus.pready = 1'b1;
      @(negedge clk);
      apb_bus.pready = 1'b0;
      chk("nto", "rsp_valid_late", rsp_valid, 1);
      chk("nto", "rsp_rdata_late", rsp_rdata, 32'hCAFE_0000);
      chk("nto", "rsp_err_late", rsp_err, 0);
      rsp_ready = 1'b1;
      @(negedge clk);
      rsp_ready = 1'b0;
      chk("nto", "idle", cmd_ready, 1);
`endif

      // ---- asynchronous reset during ACCESS ----
      @(negedge clk);
      drive_cmd(vecs[0]);
      apb_bus.pready = 1'b0;
      @(negedge clk);                       // SETUP
      cmd_valid = 1'b0;
      @(negedge clk);                       // ACCESS
      chk("arst", "psel_pre", apb_bus.psel, 1);
      #2 rst_n = 1'b0;                      // between clock edges
      #1;
      chk("arst", "psel", apb_bus.psel, 0);
      chk("arst", "penable", apb_bus.penable, 0);
      chk("arst", "rsp_valid", rsp_valid, 0);
      chk("arst", "busy", busy, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("arst", "cmd_ready", cmd_ready, 1);
      chk("arst", "no_rsp", rsp_valid, 0);
      run_vec(vecs[5], "post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
